// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: pin synchronizer, per-channel glitch filter, 4x decoder,
// signed position counter and windowed, saturated velocity sample.
//
// state     | meaning
// ST_SETTLE | filter tracks synchronized pins directly, decoder idle
// ST_RUN    | filtered levels decoded into position steps
module quad_encoder_counter #(
    parameter int CNT_WIDTH     = 32,
    parameter int VEL_WIDTH     = 16,
    parameter int SAMPLE_CYCLES = 100000,
    parameter int FILTER_LEN    = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enc_a,
    input  logic                        enc_b,
    input  logic                        clear,
    output logic signed [CNT_WIDTH-1:0] pos,
    output logic signed [VEL_WIDTH-1:0] vel,
    output logic                        vel_valid,
    output logic                        dir,
    output logic                        err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(SAMPLE_CYCLES);
    localparam int SW = $clog2(FILTER_LEN + 2);

    localparam logic [FW-1:0] FILT_LAST   = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(SAMPLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(FILTER_LEN + 1);

    localparam logic signed [CNT_WIDTH-1:0] VEL_MAX_X =
        CNT_WIDTH'((64'sd1 <<< (VEL_WIDTH - 1)) - 64'sd1);
    localparam logic signed [CNT_WIDTH-1:0] VEL_MIN_X = ~VEL_MAX_X;

    typedef enum logic {ST_SETTLE, ST_RUN} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic            settling;

    // bit 1 = channel A, bit 0 = channel B
    logic [1:0]      sync1, sync2, filt, prev;
    logic [FW-1:0]   fcnt [2];
    logic [1:0]      phase_delta;
    logic            step_fwd, step_rev, step_bad;

    logic [TW-1:0]                timer;
    logic                         terminal;
    logic signed [CNT_WIDTH-1:0]  snap;
    logic signed [CNT_WIDTH-1:0]  delta;
    logic signed [VEL_WIDTH-1:0]  vel_sat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
        end else begin
            state <= state_nxt;
            if (state == ST_SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - SW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        settling  = 1'b0;
        case (state)
            ST_SETTLE: begin
                settling = 1'b1;
                if (settle_cnt == '0)
                    state_nxt = ST_RUN;
            end
            ST_RUN:    state_nxt = ST_RUN;
            default:   state_nxt = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1   <= '0;
            sync2   <= '0;
            filt    <= '0;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (settling) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    // Gray position along the forward sequence 00 -> 10 -> 11 -> 01
    function automatic logic [1:0] enc_phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    assign phase_delta = enc_phase(filt) - enc_phase(prev);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev     <= '0;
            step_fwd <= 1'b0;
            step_rev <= 1'b0;
            step_bad <= 1'b0;
        end else begin
            prev     <= settling ? sync2 : filt;
            step_fwd <= !settling && (phase_delta == 2'd1);
            step_rev <= !settling && (phase_delta == 2'd3);
            step_bad <= !settling && (phase_delta == 2'd2);
        end
    end

    // clear has priority over a step landing in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pos <= '0;
            dir <= 1'b0;
            err <= 1'b0;
        end else begin
            err <= step_bad;
            if (clear) begin
                pos <= '0;
            end else if (step_fwd) begin
                pos <= pos + CNT_WIDTH'(1);
                dir <= 1'b1;
            end else if (step_rev) begin
                pos <= pos - CNT_WIDTH'(1);
                dir <= 1'b0;
            end
        end
    end

    assign terminal = (timer == '0);
    assign delta    = pos - snap;

    always_comb begin
        vel_sat = delta[VEL_WIDTH-1:0];
        if (delta > VEL_MAX_X)
            vel_sat = VEL_MAX_X[VEL_WIDTH-1:0];
        else if (delta < VEL_MIN_X)
            vel_sat = VEL_MIN_X[VEL_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer     <= TIMER_LOAD;
            snap      <= '0;
            vel       <= '0;
            vel_valid <= 1'b0;
        end else begin
            timer     <= terminal ? TIMER_LOAD : timer - TW'(1);
            vel_valid <= terminal;
            if (terminal)
                vel <= vel_sat;
            if (clear)
                snap <= '0;
            else if (terminal)
                snap <= pos;
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Bench for quad_encoder_counter: position, filter, illegal-step, clear and velocity behaviour.
// Expected velocity samples are queued as each window is stimulated and checked on vel_valid.
module tb_quad_encoder_counter;

    localparam int CW = 32;
    localparam int VW = 8;
    localparam int SC = 1000;
    localparam int FL = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic clear = 1'b0;
    logic signed [CW-1:0] pos;
    logic signed [VW-1:0] vel;
    logic vel_valid, dir, err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    bit vv_pending = 1'b0;
    logic signed [VW-1:0] exp_vel_q [$];
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int ph = 0;
    logic signed [CW-1:0] model_pos = '0;

    quad_encoder_counter #(
        .CNT_WIDTH(CW), .VEL_WIDTH(VW), .SAMPLE_CYCLES(SC), .FILTER_LEN(FL)
    ) dut (
        .clk(clk), .rstn(rstn), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .pos(pos), .vel(vel), .vel_valid(vel_valid), .dir(dir), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (vv_pending) begin
            check_val("vel_valid_width", 64'(vel_valid), 64'd0);
            vv_pending = 1'b0;
        end
        if (vel_valid === 1'b1 && exp_vel_q.size() != 0) begin
            check_val("vel", 64'(vel), 64'(exp_vel_q.pop_front()));
            vv_pending = 1'b1;
        end
    end

    task automatic drive_step(input bit fwd, input int hold);
        ph = fwd ? (ph + 1) % 4 : (ph + 3) % 4;
        {enc_a, enc_b} = seq[ph];
        model_pos = fwd ? model_pos + 32'sd1 : model_pos - 32'sd1;
        repeat (hold) @(negedge clk);
    endtask

    task automatic sync_window();
        int n = 0;
        while (vel_valid !== 1'b1 && n < 2 * SC) begin
            @(negedge clk);
            n++;
        end
        if (vel_valid !== 1'b1) check_val("window_sync_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_vel_q.size() != 0 && n < 3 * SC) begin
            @(negedge clk);
            n++;
        end
        if (exp_vel_q.size() != 0) begin
            check_val("vel_timeout", 64'(exp_vel_q.size()), 64'd0);
            exp_vel_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [CW-1:0] p0, peak;
        int e0, gdir;
        bit changed;

        repeat (3) @(negedge clk);
        check_val("rst_pos", 64'(pos), 64'd0);
        check_val("rst_vel", 64'(vel), 64'd0);
        check_val("rst_vel_valid", 64'(vel_valid), 64'd0);
        check_val("rst_dir", 64'(dir), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 32; i++) drive_step(1'b1, 20);
        check_val("fwd_pos", 64'(pos), 64'd32);
        check_val("fwd_dir", 64'(dir), 64'd1);
        check_val("fwd_err", 64'(err_cnt), 64'd0);

        for (int i = 0; i < 12; i++) drive_step(1'b0, 20);
        check_val("rev_pos", 64'(pos), 64'd20);
        check_val("rev_dir", 64'(dir), 64'd0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("clear_pos", 64'(pos), 64'd0);
        model_pos = '0;
        drive_step(1'b0, 20);
        check_val("rev_wrap", 64'(pos), 64'(-32'sd1));

        // short pulse on A is dropped, pulse of FILTER_LEN cycles passes and returns
        gdir = (seq[(ph + 1) % 4] == (seq[ph] ^ 2'b10)) ? 1 : -1;
        p0 = pos;
        enc_a = ~enc_a;
        repeat (FL - 1) @(negedge clk);
        enc_a = ~enc_a;
        changed = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pos !== p0) changed = 1'b1;
        end
        check_val("glitch_short", 64'(changed), 64'd0);
        enc_a = ~enc_a;
        repeat (FL) @(negedge clk);
        enc_a = ~enc_a;
        peak = p0;
        repeat (20) begin
            @(negedge clk);
            if (pos !== p0) peak = pos;
        end
        check_val("glitch_accept", 64'(peak), 64'(p0 + gdir));
        check_val("glitch_return", 64'(pos), 64'(p0));

        e0 = err_cnt;
        p0 = pos;
        {enc_a, enc_b} = seq[ph] ^ 2'b11;
        ph = (ph + 2) % 4;
        repeat (20) @(negedge clk);
        check_val("illegal_err", 64'(err_cnt - e0), 64'd1);
        check_val("illegal_pos", 64'(pos), 64'(p0));
        drive_step(1'b1, 20);
        check_val("post_illegal_pos", 64'(pos), 64'(model_pos));
        check_val("post_illegal_dir", 64'(dir), 64'd1);

        // clear lands on the same clock as the step's position update
        ph = (ph + 1) % 4;
        {enc_a, enc_b} = seq[ph];
        repeat (FL + 3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("clear_step_now", 64'(pos), 64'd0);
        repeat (15) @(negedge clk);
        check_val("clear_step_dropped", 64'(pos), 64'd0);
        model_pos = '0;

        sync_window();
        exp_vel_q.push_back(8'sd50);
        for (int i = 0; i < 50; i++) drive_step(1'b1, 10);
        drain();

        sync_window();
        exp_vel_q.push_back(8'sd127);
        for (int i = 0; i < 200; i++) drive_step(1'b1, 4);
        drain();

        sync_window();
        exp_vel_q.push_back(-8'sd128);
        for (int i = 0; i < 200; i++) drive_step(1'b0, 4);
        drain();

        drive_step(1'b1, 20);
        check_val("pre_arst_dir", 64'(dir), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("arst_pos", 64'(pos), 64'd0);
        check_val("arst_vel", 64'(vel), 64'd0);
        check_val("arst_vel_valid", 64'(vel_valid), 64'd0);
        check_val("arst_dir", 64'(dir), 64'd0);
        check_val("arst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        check_val("settle_no_step", 64'(pos), 64'd0);
        model_pos = '0;
        drive_step(1'b1, 20);
        check_val("post_arst_pos", 64'(pos), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
